seq_stream_gen: RTL and testbench

Serial stimulus transmitter for the single-bit sequence detectors in the lab set. It accepts a pattern word over a valid/ready load handshake and emits it MSB-first on w, one bit per clock, optionally repeated. It also counts the detector's z pulses during the burst. It sits in front of a detector instance (w -> detector w, detector z -> z_in) so that sequence tests run in hardware without a hand-written stimulus list.

---
 rtl/seq_stream_gen.sv | 78 +++++++
 tb/tb_seq_stream_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seq_stream_gen.sv
// seq_stream_gen: loads a pattern over valid/ready, shifts it MSB-first on w with repeats, counts detector z pulses
module seq_stream_gen #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int REP_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [REP_W-1:0] load_rep,
    output logic             w,
    output logic             w_valid,
    input  logic             z_in,
    output logic [CNT_W-1:0] z_count,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] pat;
    logic [LEN_W-1:0] len, idx, len_c, nidx;
    logic [REP_W-1:0] reps;
    logic xfer, wrap;
    assign load_ready = state == IDLE;
    assign xfer = load_valid && load_ready;
    assign len_c = load_len > LEN_W'(WIDTH) ? LEN_W'(WIDTH) : load_len;
    assign wrap = idx == '0;
    assign nidx = wrap ? len - 1'b1 : idx - 1'b1;
    // idx always names the bit currently presented on w
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            pat     <= '0;
            len     <= '0;
            idx     <= '0;
            reps    <= '0;
            w       <= 1'b0;
            w_valid <= 1'b0;
            done    <= 1'b0;
            z_count <= '0;
        end else begin
            if (xfer)
                z_count <= '0;
            else if (z_in && state != IDLE && z_count != '1)
                z_count <= z_count + 1'b1;
            case (state)
                IDLE: if (xfer) begin
                    pat     <= load_data;
                    len     <= len_c;
                    reps    <= load_rep;
                    idx     <= len_c - 1'b1;
                    state   <= len_c == '0 ? DONE : SHIFT;
                    w       <= len_c != '0 && 1'(load_data >> (len_c - 1'b1));
                    w_valid <= len_c != '0;
                    done    <= len_c == '0;
                end
                SHIFT: if (wrap && reps == '0) begin
                    state   <= DONE;
                    w       <= 1'b0;
                    w_valid <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    idx  <= nidx;
                    reps <= wrap ? reps - 1'b1 : reps;
                    w    <= 1'(pat >> nidx);
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_stream_gen.sv
// tb_seq_stream_gen: directed bursts; expected bits and done timing go to queues checked by a monitor
module tb_seq_stream_gen;
    logic clk = 1'b0, resetn = 1'b0, load_valid = 1'b0, load_ready;
    logic [15:0] load_data = '0;
    logic [4:0] load_len = '0;
    logic [3:0] load_rep = '0;
    logic w, w_valid, z_in = 1'b0, done;
    logic [7:0] z_count;
    int checks = 0, errors = 0, since = 0, zmode = 0;
    logic w_prev = 1'b0;
    bit exp_q[$];
    int done_q[$];

    seq_stream_gen dut (
        .clk(clk), .resetn(resetn), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_len(load_len), .load_rep(load_rep),
        .w(w), .w_valid(w_valid), .z_in(z_in), .z_count(z_count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // z_in follows zmode: 0 idle low, 1 w delayed one cycle, 2 held high
    initial forever begin
        @(posedge clk);
        #1;
        z_in = (zmode == 2) || (zmode == 1 && w_prev);
        w_prev = w;
    end

    always @(negedge clk) if (resetn) begin
        since++;
        if (w_valid) begin
            if (exp_q.size() == 0) chk("w_extra_bit", 1, 0);
            else chk("w_bit", w, exp_q.pop_front());
        end
        if (done) begin
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_cycle", since, done_q.pop_front());
        end
    end

    task automatic send(input logic [15:0] d, input logic [4:0] l, input logic [3:0] r,
                        input logic [63:0] e, input int n, input int nrep, input int poke);
        int t = n * nrep;
        int k = 0;
        while (!load_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", load_ready, 1);
        load_data = d;
        load_len = l;
        load_rep = r;
        load_valid = 1'b1;
        for (int j = 0; j < nrep; j++)
            for (int i = n - 1; i >= 0; i--) exp_q.push_back(e[i]);
        done_q.push_back(t + 1);
        @(posedge clk);
        since = 0;
        @(negedge clk);
        load_valid = 1'b0;
        for (int c = 1; c <= t + 1; c++) begin
            if (c == poke) begin
                load_valid = 1'b1;
                load_data = 16'hFFFF;
                load_len = 5'd4;
            end else if (c == poke + 1) load_valid = 1'b0;
            chk("ready_busy", load_ready, 0);
            @(negedge clk);
        end
        load_valid = 1'b0;
        chk("ready_after", load_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        load_valid = 1'b1;
        load_data = 16'hFFFF;
        load_len = 5'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_w", w, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_z_count", z_count, 0);
        chk("rst_ready", load_ready, 1);
        load_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", load_ready, 1);
        chk("post_rst_w_valid", w_valid, 0);

        send(16'h02DD, 5'd11, 4'd0, 64'b01011011101, 11, 1, 0);
        chk("basic_z_count", z_count, 0);

        zmode = 1;
        send(16'h0005, 5'd3, 4'd2, 64'b101, 3, 3, 0);
        chk("repeat_z_count", z_count, 6);
        zmode = 0;

        send(16'hFFFF, 5'd0, 4'd0, 64'b0, 0, 1, 0);
        chk("len0_z_count", z_count, 0);

        send(16'hA5C3, 5'd20, 4'd0, 64'b1010010111000011, 16, 1, 0);

        zmode = 2;
        send(16'h00A7, 5'd8, 4'd0, 64'b10100111, 8, 1, 3);
        chk("stall_z_count", z_count, 9);

        send(16'hFFFF, 5'd16, 4'd15, 64'hFFFF, 16, 16, 0);
        chk("sat_z_count", z_count, 255);

        load_data = 16'h02DD;
        load_len = 5'd11;
        load_rep = 4'd0;
        load_valid = 1'b1;
        for (int i = 10; i >= 6; i--) exp_q.push_back(load_data[i]);
        @(posedge clk);
        since = 0;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_z_count_before", z_count, 4);
        #1 resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_w_valid", w_valid, 0);
        chk("mid_rst_w", w, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_z_count", z_count, 0);
        chk("mid_rst_ready", load_ready, 1);
        zmode = 0;
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("bits_drained", exp_q.size(), 0);
        chk("dones_drained", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
